// File: rtl/mpu_matrix_streamer.sv
// Matrix read-out stage: captures one flat DIM x DIM matrix and streams its elements
// one per beat with row/col/last tags. Optional column-major order: MPU_STREAM_TRANSPOSE_EN.
//
// state  | meaning
// IDLE   | waiting for a matrix; in_ready=1, out_valid=0
// STREAM | emitting buffered elements; in_ready=0, out_valid=1

module mpu_matrix_streamer #(
    parameter int DIM = 5,
    parameter int W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W*DIM*DIM-1:0] in_matrix,
`ifdef MPU_STREAM_TRANSPOSE_EN
    input  logic                 transpose,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_data,
    output logic [2:0]           out_row,
    output logic [2:0]           out_col,
    output logic                 out_last,
    output logic                 busy
);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    localparam logic [2:0] MAX_IDX = 3'(DIM - 1);

    state_t               state;
    logic [W*DIM*DIM-1:0] mat_q;
    logic [2:0]           row_q;
    logic [2:0]           col_q;
    logic                 col_major_q;
    logic                 col_major_in;
    logic [2:0]           row_nxt;
    logic [2:0]           col_nxt;
    logic                 last_nxt;

`ifdef MPU_STREAM_TRANSPOSE_EN
    assign col_major_in = transpose;
`else
    assign col_major_in = 1'b0;
`endif

    // Next stream position; the fast-moving index depends on the captured order.
    always_comb begin
        row_nxt = row_q;
        col_nxt = col_q;
        if (col_major_q) begin
            if (row_q == MAX_IDX) begin
                row_nxt = 3'd0;
                col_nxt = col_q + 3'd1;
            end else begin
                row_nxt = row_q + 3'd1;
            end
        end else begin
            if (col_q == MAX_IDX) begin
                col_nxt = 3'd0;
                row_nxt = row_q + 3'd1;
            end else begin
                col_nxt = col_q + 3'd1;
            end
        end
        last_nxt = (row_nxt == MAX_IDX) && (col_nxt == MAX_IDX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mat_q       <= '0;
            row_q       <= 3'd0;
            col_q       <= 3'd0;
            col_major_q <= 1'b0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            busy        <= 1'b0;
            in_ready    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mat_q       <= in_matrix;
                        col_major_q <= col_major_in;
                        row_q       <= 3'd0;
                        col_q       <= 3'd0;
                        state       <= STREAM;
                        out_valid   <= 1'b1;
                        out_last    <= 1'b0;
                        busy        <= 1'b1;
                        in_ready    <= 1'b0;
                    end
                end
                STREAM: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state     <= IDLE;
                            row_q     <= 3'd0;
                            col_q     <= 3'd0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            in_ready  <= 1'b1;
                        end else begin
                            row_q    <= row_nxt;
                            col_q    <= col_nxt;
                            out_last <= last_nxt;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign out_row = row_q;
    assign out_col = col_q;

    // Element (i,j) sits at bit offset W*(i+DIM*j) in the buffer.
    always_comb begin
        out_data = '0;
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
                if (row_q == 3'(i) && col_q == 3'(j)) begin
                    out_data = mat_q[W*(i+DIM*j) +: W];
                end
            end
        end
    end

endmodule

// File: doc/mpu_matrix_streamer.md
# mpu_matrix_streamer

Sequential read-out stage for the matrix processing unit (MPU). It accepts one flat 5x5 result matrix over a valid/ready handshake and emits its 25 elements one per beat on a byte stream. Each beat is tagged with its row, column and last-beat flag. The block sits between the combinational MPU operators and the serial host link, which makes it the consumer end of the flat-matrix interface those operators drive.

## Interface
- `DIM`, default 5: matrix dimension; supported range 2..8.
- `W`, default 8: element width in bits.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `in_valid`, input, 1: `in_matrix` is valid.
- `in_ready`, output, 1: block can capture a matrix.
- `in_matrix`, input, W*DIM*DIM: flat matrix; element (i,j) at bits [W*(i+DIM*j) +: W], where i is the row and j is the column.
- `out_valid`, output, 1: `out_data` and the tags are valid.
- `out_ready`, input, 1: downstream accepts the beat.
- `out_data`, output, W: current element.
- `out_row`, output, 3: row index i of `out_data`.
- `out_col`, output, 3: column index j of `out_data`.
- `out_last`, output, 1: high on the final (DIM*DIM-th) beat.
- `busy`, output, 1: high in STREAM.

## Operation
- States:
  - IDLE: reset state. `in_ready`=1, `out_valid`=0.
  - STREAM: `in_ready`=0, `out_valid`=1.
- Capture:
  - In IDLE with `in_valid`=1, `in_matrix` is registered into an internal buffer.
  - The row and column counters clear to 0 and the state moves to STREAM.
  - The input is not sampled at any other time. Changes on `in_matrix` after capture have no effect.
- Stream order (default) is row-major: the column counter increments first, from 0 to DIM-1. On wrap it returns to 0 and the row counter increments.
- Beat transfer:
  - A beat transfers when `out_valid` and `out_ready` are both high.
  - The counters advance only on a transfer.
  - While `out_ready`=0, `out_data`, `out_row`, `out_col` and `out_last` hold stable.
- `out_last` is 1 exactly when the stream position is the final one: (row,col)=(DIM-1,DIM-1) in row-major order, (DIM-1,DIM-1) in column-major order as well.
- A transfer with `out_last`=1 returns the state to IDLE and clears the counters.
- `out_data` is always the buffer element at the current (`out_row`,`out_col`). This is a combinational mux from registered state, with no combinational path from `in_*` to `out_*`.
- Reset values, all asserted asynchronously when `rst_n` goes low, including mid-stream:
  - State IDLE.
  - `out_valid`=0, `out_last`=0, `busy`=0.
  - `out_row`=0, `out_col`=0, `out_data`=0.
  - Buffer cleared to 0.
  - `in_ready`=1 once `rst_n` is high.
- A stream interrupted by reset is discarded. No partial-completion indication is given.

## Timing
- Capture edge N (IDLE, `in_valid`=1) gives first beat valid at N+1.
- Minimum matrix period, with `out_ready` held high: 1 capture cycle + DIM*DIM beats = 26 cycles for DIM=5.
- No back-to-back overlap: `in_ready` rises in the cycle after the last-beat transfer.
- `in_ready` depends on state only, never on `in_valid`.
- `out_valid` never drops once asserted until the last beat transfers.

## Configuration
- Macro: `MPU_STREAM_TRANSPOSE_EN`.
- Defined:
  - Adds input port `transpose` (1 bit), sampled together with `in_matrix` on capture.
  - If the captured `transpose` value is 1, the stream is column-major: the row counter increments first, the column wraps second. This emits the transpose of the matrix with no extra MPU pass.
  - The tags always report the true source (row,col).
  - If the captured value is 0, the stream is row-major.
- Undefined: the `transpose` port is absent and the stream is always row-major.

## Test plan
- Row-major order:
  - Stimulus: reset, then capture a matrix with element (i,j)=10*i+j, `out_ready`=1.
  - Response: beats 0,1,2,3,4,10,…,44 on consecutive cycles starting one cycle after capture; `out_last` only on 44; `in_ready` back at 1 on the following cycle.
- Backpressure:
  - Stimulus: same matrix, `out_ready` toggled 1,0,0,1 repeating.
  - Response: no beat lost or duplicated; `out_data`/`out_row`/`out_col` stable during every stall; 25 transfers total.
- Input isolation:
  - Stimulus: change `in_matrix` to all 8'hFF and hold `in_valid`=1 during STREAM.
  - Response: stream still matches the captured values; `in_ready`=0 throughout.
- Reset mid-stream:
  - Stimulus: assert `rst_n`=0 asynchronously after beat 7.
  - Response: `out_valid`=0 immediately; after release, IDLE with `in_ready`=1; a new capture streams from (0,0).
- Back-to-back matrices:
  - Stimulus: two matrices, with `in_valid` held high.
  - Response: second capture occurs on the cycle after the first last-beat transfer; 52-cycle total for both.
- Transposed order (`MPU_STREAM_TRANSPOSE_EN`):
  - Stimulus: `transpose`=1 with the matrix from the first scenario.
  - Response: beats 0,10,20,30,40,1,…,44 with tags (0,0),(1,0),…; `out_last` on (4,4).
